// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : Pipeline writeback stage. Captures a retiring instruction
//                from MEM, selects ALU or load data, and issues a single
//                register-file write strobe per accepted instruction. Also
//                counts retired instructions.
//                Optional macro WB_LOAD_SUBWORD_EN enables byte/halfword
//                load formatting. When it is undefined, loads write the raw
//                memory word.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        stall,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_data,
    input  logic [2:0]  in_load_type,
    output logic        write_back_en,
    output logic [4:0]  write_back_reg,
    output logic [31:0] write_back,
    output logic [31:0] retire_count
);

    localparam logic [2:0] c_LT_LB  = 3'b001;
    localparam logic [2:0] c_LT_LBU = 3'b010;
    localparam logic [2:0] c_LT_LH  = 3'b011;
    localparam logic [2:0] c_LT_LHU = 3'b100;

    logic        r_valid;
    logic        r_fresh;
    logic        r_reg_write;
    logic [31:0] w_load_value;
    logic [31:0] w_result;

`ifdef WB_LOAD_SUBWORD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword lane and extend it by load type
    always_comb begin
        w_byte       = 8'd0;
        w_half       = 16'd0;
        w_load_value = in_mem_data;
        case (in_alu_result[1:0])
            2'd0:    w_byte = in_mem_data[7:0];
            2'd1:    w_byte = in_mem_data[15:8];
            2'd2:    w_byte = in_mem_data[23:16];
            default: w_byte = in_mem_data[31:24];
        endcase
        // Halfword lane uses address bit 1 only; bit 0 is ignored
        w_half = in_alu_result[1] ? in_mem_data[31:16] : in_mem_data[15:0];
        case (in_load_type)
            c_LT_LB:  w_load_value = {{24{w_byte[7]}}, w_byte};
            c_LT_LBU: w_load_value = {24'd0, w_byte};
            c_LT_LH:  w_load_value = {{16{w_half[15]}}, w_half};
            c_LT_LHU: w_load_value = {16'd0, w_half};
            default:  w_load_value = in_mem_data;
        endcase
    end
`else
    logic w_unused_load_type;

    // Without subword support every load returns the raw word
    assign w_load_value       = in_mem_data;
    assign w_unused_load_type = ^{in_load_type, c_LT_LB, c_LT_LBU, c_LT_LH, c_LT_LHU};
`endif

    // Result mux: memory data for loads, ALU result otherwise
    assign w_result = in_mem_to_reg ? w_load_value : in_alu_result;

    // Stage accepts whenever downstream is not holding it
    assign in_ready = ~stall;

    // Strobe only on the first cycle an instruction is present so a
    // stalled instruction writes exactly once; $zero is never written
    assign write_back_en = r_valid & r_fresh & r_reg_write & (write_back_reg != 5'd0);

    // Capture, bubble or hold the stage contents; count accepted instructions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid        <= 1'b0;
            r_fresh        <= 1'b0;
            r_reg_write    <= 1'b0;
            write_back_reg <= 5'd0;
            write_back     <= 32'd0;
            retire_count   <= 32'd0;
        end else if (!stall) begin
            if (in_valid) begin
                r_valid        <= 1'b1;
                r_fresh        <= 1'b1;
                r_reg_write    <= in_reg_write;
                write_back_reg <= in_rd;
                write_back     <= w_result;
                retire_count   <= retire_count + 32'd1;
            end else begin
                r_valid <= 1'b0;
                r_fresh <= 1'b0;
            end
        end else begin
            r_fresh <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits, register index fixed at 5 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  MEM stage presents a retiring instruction.
REQ-005 in_ready  output  1  stage accepts the presented instruction this cycle.
REQ-006 stall  input  1  downstream hold; freezes stage contents.
REQ-007 in_reg_write  input  1  instruction writes a register.
REQ-008 in_mem_to_reg  input  1  1 = result from memory data, 0 = result from ALU.
REQ-009 in_rd  input  5  destination register index.
REQ-010 in_alu_result  input  32  ALU result; for loads, the effective address.
REQ-011 in_mem_data  input  32  raw 32-bit word read from data memory.
REQ-012 in_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 treated as LW.
REQ-013 write_back_en  output  1  register-file write strobe.
REQ-014 write_back_reg  output  5  register-file write index.
REQ-015 write_back  output  32  register-file write data.
REQ-016 retire_count  output  32  count of retired instructions.

Function
REQ-017 in_ready SHALL equal ~stall (combinational).
REQ-018 On a rising edge with in_valid=1 and in_ready=1, the stage SHALL capture the instruction; valid_q<=1; fresh_q<=1.
REQ-019 On a rising edge with in_ready=1 and in_valid=0, the stage SHALL insert a bubble: valid_q<=0, fresh_q<=0.
REQ-020 On a rising edge with stall=1, the stage SHALL hold every captured field and SHALL clear fresh_q.
REQ-021 write_back_reg and write_back SHALL be registered and computed at capture time; latency from accept edge to valid outputs is 1 cycle.
REQ-022 write_back_en SHALL be 1 only when valid_q & fresh_q & reg_write_q & (rd_q != 0); each instruction therefore writes exactly once, even when held under stall.
REQ-023 A captured instruction with rd=0 SHALL never assert write_back_en; it still counts as retired.
REQ-024 write_back SHALL be in_alu_result when in_mem_to_reg=0, and the formatted load value when in_mem_to_reg=1.
REQ-025 retire_count SHALL increment by 1 on each edge following which valid_q & fresh_q holds (once per accepted instruction) and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 While not fresh (bubble or held), write_back_reg and write_back SHALL keep their last values.

Reset
REQ-027 While rst=0: valid_q=0, fresh_q=0, write_back_en=0, write_back_reg=0, write_back=0, retire_count=0, asynchronously.
REQ-028 Assertion of reset during a stall SHALL discard the held instruction; no write SHALL follow reset release until a new instruction is accepted.

Configuration
REQ-029 Macro WB_LOAD_SUBWORD_EN defined: the load value SHALL be formatted by in_load_type using in_alu_result[1:0] as the little-endian byte lane (lane 0 = bits 7:0). LB/LH sign-extend, LBU/LHU zero-extend. Halfwords use in_alu_result[1] for lane select; in_alu_result[0] is ignored.
REQ-030 Macro WB_LOAD_SUBWORD_EN undefined: in_load_type SHALL remain a port but be ignored; every load SHALL write in_mem_data unchanged.

Verification
REQ-031 Reset: rst=0 with arbitrary inputs -> all outputs 0; release, idle 3 cycles -> write_back_en stays 0, retire_count=0.
REQ-032 ALU write: accept rd=5, alu=0x0000_1234, reg_write=1, mem_to_reg=0 -> next cycle write_back_en=1, reg=5, data=0x0000_1234, for exactly one cycle; retire_count=1.
REQ-033 Stall hold: accept rd=7, then stall=1 for 4 cycles with in_valid=1 -> in_ready=0; write_back_en high for only the first cycle; retire_count +1 only; held input accepted on the edge after stall drops.
REQ-034 $zero: accept rd=0, reg_write=1 -> write_back_en never 1; retire_count increments.
REQ-035 Subword (macro on): mem_data=0x80FF_7F01, addr[1:0]=3, LB -> 0xFFFF_FF80; LBU -> 0x0000_0080; addr=2, LH -> 0xFFFF_80FF; addr=0, LHU -> 0x0000_7F01; macro off, same LB -> 0x80FF_7F01.
REQ-036 Reset mid-stall plus counter wrap: hold an entry under stall and assert rst -> no write after release; force 2^32 accepts (or preload via hierarchy to 0xFFFF_FFFF) -> retire_count=0 after the next accept.
